// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================
// Package : uart_pkg
// Brief   : Constants, RX state encoding and helpers shared by the UART blocks.
// Revision: 1.0
// ============================================================
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 5208;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
`ifdef RX_PARITY_EN
        PARITY    = 3'd5,
`endif
        WAIT_IDLE = 3'd4
    } rx_state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/receiver_if.sv
`default_nettype none
// ============================================================
// Interface : receiver_if
// Brief     : Serial line in and received-byte outputs of the UART receiver.
// Revision  : 1.0
// ============================================================
interface receiver_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] dataout;
    logic                 valid;
    logic                 busy;
    logic                 frame_err;

    modport master (output rx, input dataout, input valid, input busy, input frame_err);
    modport slave  (input rx, output dataout, output valid, output busy, output frame_err);

endinterface
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================
// Module  : uart_sync
// Brief   : Two-flop synchronizer with selectable reset value.
// Revision: 1.0
// ============================================================
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule
`default_nettype wire

// File: rtl/receiver.sv
`default_nettype none
// ============================================================
// Module  : receiver
// Brief   : 8N1 UART receiver; define RX_PARITY_EN for an even-parity bit.
// Revision: 1.0
// ============================================================
module receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic      clk,
    input  logic      rstn,
    receiver_if.slave rif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] c_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] c_DATA_LAST = BW'(DATA_BITS - 1);

    logic w_rx;

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 w_par_bad;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (rif.rx),
        .q_o  (w_rx)
    );

`ifdef RX_PARITY_EN
    logic par_err_q, par_err_d;
    assign w_par_bad = par_err_q;
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!w_rx) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Mid start bit: a line that is high again was only a glitch.
                if (cnt_q == c_HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = w_rx ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == c_BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {w_rx, shreg_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == c_DATA_LAST) begin
`ifdef RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (cnt_q == c_BIT_LAST) begin
                    cnt_d     = '0;
                    par_err_d = (even_parity(shreg_q) != w_rx);
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == c_BIT_LAST) begin
                    cnt_d = '0;
                    if (w_rx && !w_par_bad) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = w_rx ? IDLE : WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                // A held-low line (break) must not be read as a stream of frames.
                if (w_rx) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rif.dataout   = data_q;
    assign rif.valid     = valid_q;
    assign rif.frame_err = ferr_q;
    assign rif.busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_receiver.sv
`default_nettype none
// ============================================================
// Module  : tb_receiver
// Brief   : Directed self-checking bench for the UART receiver (CLKS_PER_BIT = 16).
// Revision: 1.0
// ============================================================
module tb_receiver;

    localparam int CPB = 16;
`ifdef RX_PARITY_EN
    localparam int LAT_MIN = CPB * 21 / 2;
`else
    localparam int LAT_MIN = CPB * 19 / 2;
`endif
    localparam int LAT_MAX = LAT_MIN + 3;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;
    int   cyc;
    int   vcnt;
    int   fcnt;
    int   both_cnt;
    int   valid_cyc;
    int   t_start;
    logic [7:0] vq[$];

    receiver_if rif ();

    receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rstn (rstn),
        .rif  (rif)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rif.valid === 1'b1) begin
            vq.push_back(rif.dataout);
            vcnt++;
            valid_cyc = cyc;
        end
        if (rif.frame_err === 1'b1) fcnt++;
        if (rif.valid === 1'b1 && rif.frame_err === 1'b1) both_cnt++;
    end

    task automatic clear_mon();
        vq.delete();
        vcnt = 0;
        fcnt = 0;
    endtask

    task automatic drive_bit(input logic v);
        rif.rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rif.rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef RX_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stop);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        rif.rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rif.dataout !== 8'h00) begin failures++; $display("FAIL reset_dataout: got %h want 00", rif.dataout); end
        checks++; if (rif.valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", rif.valid); end
        checks++; if (rif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", rif.busy); end
        checks++; if (rif.frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b want 0", rif.frame_err); end
        rstn = 1'b1;
        idle_bits(1);
    endtask

    task automatic test_single();
        int lat;
        clear_mon();
        send_frame(8'h4A, 1'b1, 1'b1);
        idle_bits(2);
        lat = valid_cyc - t_start;
        checks++; if (vcnt !== 1) begin failures++; $display("FAIL single_vcnt: got %0d want 1", vcnt); end
        checks++; if (rif.dataout !== 8'h4A) begin failures++; $display("FAIL single_data: got %h want 4a", rif.dataout); end
        checks++; if (fcnt !== 0) begin failures++; $display("FAIL single_ferr: got %0d want 0", fcnt); end
        checks++; if (rif.busy !== 1'b0) begin failures++; $display("FAIL single_busy: got %b want 0", rif.busy); end
        checks++; if (lat < LAT_MIN || lat > LAT_MAX) begin failures++; $display("FAIL single_latency: got %0d want %0d..%0d", lat, LAT_MIN, LAT_MAX); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
        clear_mon();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1);
        idle_bits(2);
        checks++; if (vcnt !== 3) begin failures++; $display("FAIL b2b_vcnt: got %0d want 3", vcnt); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (vq.size() <= i || vq[i] !== exp_b[i]) begin
                failures++;
                $display("FAIL b2b_byte%0d: got %h want %h", i, (vq.size() > i) ? vq[i] : 8'hxx, exp_b[i]);
            end
        end
        checks++; if (fcnt !== 0) begin failures++; $display("FAIL b2b_ferr: got %0d want 0", fcnt); end
    endtask

    task automatic test_glitch();
        int busy_n;
        busy_n = 0;
        clear_mon();
        rif.rx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 4) rif.rx = 1'b1;
            if (rif.busy === 1'b1) busy_n++;
        end
        checks++; if (vcnt !== 0 || fcnt !== 0) begin failures++; $display("FAIL glitch_pulses: got valid=%0d ferr=%0d want 0/0", vcnt, fcnt); end
        checks++; if (busy_n < 1 || busy_n > 8) begin failures++; $display("FAIL glitch_busy_len: got %0d want 1..8", busy_n); end
        checks++; if (rif.busy !== 1'b0) begin failures++; $display("FAIL glitch_idle: got busy=%b want 0", rif.busy); end
    endtask

    task automatic test_break();
        clear_mon();
        send_frame(8'hA5, 1'b0, 1'b0);
        rif.rx = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        checks++; if (fcnt !== 1) begin failures++; $display("FAIL break_ferr: got %0d want 1", fcnt); end
        checks++; if (vcnt !== 0) begin failures++; $display("FAIL break_valid: got %0d want 0", vcnt); end
        checks++; if (rif.dataout !== 8'h55) begin failures++; $display("FAIL break_data: got %h want 55", rif.dataout); end
        checks++; if (rif.busy !== 1'b1) begin failures++; $display("FAIL break_wait: got busy=%b want 1", rif.busy); end
        idle_bits(2);
        checks++; if (rif.busy !== 1'b0) begin failures++; $display("FAIL break_release: got busy=%b want 0", rif.busy); end
        clear_mon();
        send_frame(8'h3C, 1'b0, 1'b1);
        idle_bits(2);
        checks++; if (vcnt !== 1 || rif.dataout !== 8'h3C) begin failures++; $display("FAIL break_next: got n=%0d data=%h want 1/3c", vcnt, rif.dataout); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rif.rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        checks++; if (rif.dataout !== 8'h00) begin failures++; $display("FAIL rstmid_data: got %h want 00", rif.dataout); end
        checks++; if (rif.busy !== 1'b0 || rif.valid !== 1'b0 || rif.frame_err !== 1'b0) begin failures++; $display("FAIL rstmid_flags: got busy=%b valid=%b ferr=%b want 0", rif.busy, rif.valid, rif.frame_err); end
        idle_bits(12);
        checks++; if (vcnt !== 0 || fcnt !== 0) begin failures++; $display("FAIL rstmid_partial: got valid=%0d ferr=%0d want 0/0", vcnt, fcnt); end
        send_frame(8'h81, 1'b0, 1'b1);
        idle_bits(2);
        checks++; if (vcnt !== 1 || rif.dataout !== 8'h81) begin failures++; $display("FAIL rstmid_next: got n=%0d data=%h want 1/81", vcnt, rif.dataout); end
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity();
        clear_mon();
        send_frame(8'h4A, 1'b1, 1'b1);
        idle_bits(2);
        checks++; if (vcnt !== 1 || fcnt !== 0 || rif.dataout !== 8'h4A) begin failures++; $display("FAIL parity_good: got n=%0d ferr=%0d data=%h want 1/0/4a", vcnt, fcnt, rif.dataout); end
        clear_mon();
        send_frame(8'h4A, 1'b0, 1'b1);
        idle_bits(2);
        checks++; if (vcnt !== 0 || fcnt !== 1) begin failures++; $display("FAIL parity_bad: got valid=%0d ferr=%0d want 0/1", vcnt, fcnt); end
        checks++; if (rif.busy !== 1'b0) begin failures++; $display("FAIL parity_idle: got busy=%b want 0", rif.busy); end
    endtask
`endif

    task automatic test_exclusive();
        checks++; if (both_cnt !== 0) begin failures++; $display("FAIL valid_ferr_overlap: got %0d cycles want 0", both_cnt); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        vcnt      = 0;
        fcnt      = 0;
        both_cnt  = 0;
        valid_cyc = 0;
        t_start   = 0;
        rstn      = 1'b0;
        rif.rx    = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_mid();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
